// File: rtl/seq_compare_unit_if.sv
// seq_compare_unit_if
//   Bundles the request and response handshakes of seq_compare_unit.
//   master: the requester. It drives in_valid, a, b, cmp_op and out_ready,
//           and observes in_ready, out_valid, result, eq_flag and lt_flag.
//   slave : the compare unit, with the opposite directions.
//   Parameter WIDTH sets the operand and result width.
interface seq_compare_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       cmp_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             eq_flag;
  logic             lt_flag;

  modport master (
    output in_valid, a, b, cmp_op, out_ready,
    input  in_ready, out_valid, result, eq_flag, lt_flag
  );

  modport slave (
    input  in_valid, a, b, cmp_op, out_ready,
    output in_ready, out_valid, result, eq_flag, lt_flag
  );
endinterface

// File: rtl/seq_compare_unit.sv
// seq_compare_unit
//   Multi-cycle comparator that sits beside the ALU. It compares two WIDTH-bit
//   operands CHUNK bits per cycle, starting at the most significant chunk.
//   Eight compare ops are supported:
//     0 EQ, 1 NE, 2 LT, 3 LTU, 4 LE, 5 LEU, 6 GT, 7 GTU
//   LT, LE and GT are signed. The result is a zero-extended 0/1 word.
// Ports
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : seq_compare_unit_if.slave
//         request  : in_valid / in_ready, a, b, cmp_op
//         response : out_valid / out_ready, result, eq_flag, lt_flag
// Parameters
//   WIDTH : operand width; must be a multiple of CHUNK
//   CHUNK : bits examined per scan cycle
// Build option
//   CMP_EARLY_EXIT_EN : when defined, the scan finishes on the edge where the
//                       first unequal chunk is found. Results are identical.
module seq_compare_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic                clk,
  input logic                rst,
  seq_compare_unit_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  typedef enum logic [1:0] {EQUAL, LESS, GREATER} cmp_t;

  state_t           state_q, state_d;
  cmp_t             cmp_q, cmp_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  cmp_t             cmp_scan;
  logic             scan_done;
  logic             pred;

  // Signed ops are turned into unsigned ones by flipping the sign bit of both
  // operands, which maps the two's complement order onto the unsigned order.
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
  endfunction

  function automatic logic predicate(input logic [2:0] op, input logic eq, input logic lt);
    case (op)
      3'd0:       return eq;
      3'd1:       return !eq;
      3'd2, 3'd3: return lt;
      3'd4, 3'd5: return lt | eq;
      default:    return !lt & !eq;
    endcase
  endfunction

  // Chunk currently under inspection, selected by the scan index.
  always_comb begin
    a_chunk = CHUNK'(a_q >> (int'(idx_q) * CHUNK));
    b_chunk = CHUNK'(b_q >> (int'(idx_q) * CHUNK));
  end

  // Next-state and datapath logic for the IDLE -> SCAN -> DONE sequence.
  always_comb begin
    state_d   = state_q;
    cmp_d     = cmp_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    idx_d     = idx_q;
    result_d  = result_q;
    eq_d      = eq_q;
    lt_d      = lt_q;
    cmp_scan  = cmp_q;
    scan_done = 1'b0;
    pred      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = is_signed_op(bus.cmp_op) ? (bus.a ^ MSB_MASK) : bus.a;
          b_d     = is_signed_op(bus.cmp_op) ? (bus.b ^ MSB_MASK) : bus.b;
          op_d    = bus.cmp_op;
          idx_d   = IDX_TOP;
          cmp_d   = EQUAL;
          state_d = SCAN;
        end
      end

      SCAN: begin
        // The first unequal chunk decides the order; later chunks cannot
        // override it.
        if ((cmp_q == EQUAL) && (a_chunk != b_chunk)) begin
          cmp_scan = (a_chunk < b_chunk) ? LESS : GREATER;
        end
        cmp_d     = cmp_scan;
        scan_done = (idx_q == '0);
`ifdef CMP_EARLY_EXIT_EN
        if (cmp_scan != EQUAL) begin
          scan_done = 1'b1;
        end
`else
`endif
        if (scan_done) begin
          eq_d     = (cmp_scan == EQUAL);
          lt_d     = (cmp_scan == LESS);
          pred     = predicate(op_q, cmp_scan == EQUAL, cmp_scan == LESS);
          result_d = WIDTH'(pred);
          state_d  = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cmp_q    <= EQUAL;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      idx_q    <= IDX_TOP;
      result_q <= '0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmp_q    <= cmp_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.eq_flag   = eq_q;
  assign bus.lt_flag   = lt_q;

endmodule

// File: tb/tb_seq_compare_unit.sv
// tb_seq_compare_unit
//   Randomised and directed bench for seq_compare_unit (WIDTH=32, CHUNK=8).
//   Expected predicates, flags and latencies come from a reference model that
//   works directly on the operand values with signed/unsigned arithmetic.
module tb_seq_compare_unit;

  localparam int WIDTH   = 32;
  localparam int CHUNK   = 8;
  localparam int NCHUNK  = WIDTH / CHUNK;
  localparam int TIMEOUT = 64;

  logic clk;
  logic rst;
  int   check_count = 0;
  int   pass_count  = 0;

  seq_compare_unit_if #(.WIDTH(WIDTH)) bus ();

  seq_compare_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Reference model: predicate straight from the operation's meaning.
  function automatic logic model_pred(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd2:    return $signed(a) < $signed(b);
      3'd3:    return a < b;
      3'd4:    return $signed(a) <= $signed(b);
      3'd5:    return a <= b;
      3'd6:    return $signed(a) > $signed(b);
      default: return a > b;
    endcase
  endfunction

  function automatic logic model_lt(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (op == 3'd2 || op == 3'd4 || op == 3'd6) return $signed(a) < $signed(b);
    return a < b;
  endfunction

  function automatic int model_latency(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef CMP_EARLY_EXIT_EN
    int n;
    n = 0;
    if (a == b) return NCHUNK;
    for (int i = NCHUNK - 1; i >= 0; i--) begin
      if (a[i*CHUNK +: CHUNK] != b[i*CHUNK +: CHUNK]) break;
      n++;
    end
    return n + 1;
`else
    return NCHUNK;
`endif
  endfunction

  // Issue one request, scramble the inputs after capture, then wait for
  // out_valid. Latency is the number of edges after the capture edge, or -1
  // if the result never appears.
  task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                               input logic [2:0] op, output int lat,
                               output logic [WIDTH-1:0] res, output logic eq, output logic lt);
    int guard;
    guard = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && guard < TIMEOUT) begin
      @(negedge clk);
      guard++;
    end
    bus.a        = ta;
    bus.b        = tb_v;
    bus.cmp_op   = op;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.cmp_op   = 3'($urandom_range(0, 7));
    lat = -1;
    for (int i = 1; i <= TIMEOUT; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    res = bus.result;
    eq  = bus.eq_flag;
    lt  = bus.lt_flag;
  endtask

  task automatic popResult();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  // Reset values, with in_valid asserted throughout reset.
  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.a = 32'hDEADBEEF;
    bus.b = 32'h1;
    bus.cmp_op = 3'd1;
    repeat (3) @(posedge clk);
    #1;
    check_count++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready); else pass_count++;
    check_count++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid); else pass_count++;
    check_count++; if (bus.result !== '0) $display("[TB] FAIL reset_result: got %h want 0", bus.result); else pass_count++;
    check_count++; if (bus.eq_flag !== 1'b0) $display("[TB] FAIL reset_eq: got %b want 0", bus.eq_flag); else pass_count++;
    check_count++; if (bus.lt_flag !== 1'b0) $display("[TB] FAIL reset_lt: got %b want 0", bus.lt_flag); else pass_count++;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_count++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL post_reset_idle: got %b want 1", bus.in_ready); else pass_count++;
  endtask

  // Directed vectors covering signedness, equality and sign boundaries.
  task automatic test_directed();
    logic [WIDTH-1:0] va [10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'h12345678,
                                   32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
                                   32'h80000000, 32'h00000100};
    logic [WIDTH-1:0] vb [10] = '{32'h00000001, 32'h00000001, 32'h12345678, 32'h12345678,
                                   32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
                                   32'h00000000, 32'h00000101};
    logic [2:0] vop [10] = '{3'd2, 3'd3, 3'd0, 3'd1, 3'd6, 3'd7, 3'd4, 3'd5, 3'd3, 3'd3};
    int lat;
    logic [WIDTH-1:0] res;
    logic eq, lt;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(va[i], vb[i], vop[i], lat, res, eq, lt);
      check_count++; if (lat !== model_latency(va[i], vb[i])) $display("[TB] FAIL dir%0d_latency: got %0d want %0d", i, lat, model_latency(va[i], vb[i])); else pass_count++;
      check_count++; if (res !== WIDTH'(model_pred(vop[i], va[i], vb[i]))) $display("[TB] FAIL dir%0d_result: got %h want %h", i, res, WIDTH'(model_pred(vop[i], va[i], vb[i]))); else pass_count++;
      check_count++; if (eq !== (va[i] == vb[i])) $display("[TB] FAIL dir%0d_eq: got %b want %b", i, eq, va[i] == vb[i]); else pass_count++;
      check_count++; if (lt !== model_lt(vop[i], va[i], vb[i])) $display("[TB] FAIL dir%0d_lt: got %b want %b", i, lt, model_lt(vop[i], va[i], vb[i])); else pass_count++;
      popResult();
    end
  endtask

  // Result held under back-pressure, requests ignored while busy, and the
  // next request accepted only on the edge after the pop.
  task automatic test_back_to_back();
    logic [WIDTH-1:0] res;
    logic eq, lt;
    int lat;
    logic exp_res;
    applyStimulus(32'hFFFFFFFF, 32'h1, 3'd2, lat, res, eq, lt);
    exp_res = model_pred(3'd2, 32'hFFFFFFFF, 32'h1);
    check_count++; if (lat !== NCHUNK) $display("[TB] FAIL hold_latency: got %0d want %0d", lat, NCHUNK); else pass_count++;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.in_valid = (c == 2);
      if (c == 2) begin
        bus.a = 32'h0;
        bus.b = 32'h0;
        bus.cmp_op = 3'd0;
      end
      @(posedge clk);
      #1;
      check_count++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL hold%0d_out_valid: got %b want 1", c, bus.out_valid); else pass_count++;
      check_count++; if (bus.result !== WIDTH'(exp_res)) $display("[TB] FAIL hold%0d_result: got %h want %h", c, bus.result, WIDTH'(exp_res)); else pass_count++;
      check_count++; if (bus.lt_flag !== 1'b1 || bus.eq_flag !== 1'b0) $display("[TB] FAIL hold%0d_flags: got lt=%b eq=%b want lt=1 eq=0", c, bus.lt_flag, bus.eq_flag); else pass_count++;
      check_count++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL hold%0d_in_ready: got %b want 0", c, bus.in_ready); else pass_count++;
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.a = 32'd3;
    bus.b = 32'd9;
    bus.cmp_op = 3'd3;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check_count++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL pop_out_valid: got %b want 0", bus.out_valid); else pass_count++;
    check_count++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL pop_no_capture: got %b want 1", bus.in_ready); else pass_count++;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    check_count++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL next_capture: got %b want 0", bus.in_ready); else pass_count++;
    lat = -1;
    for (int i = 1; i <= TIMEOUT; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    check_count++; if (lat !== model_latency(32'd3, 32'd9)) $display("[TB] FAIL next_latency: got %0d want %0d", lat, model_latency(32'd3, 32'd9)); else pass_count++;
    check_count++; if (bus.result !== WIDTH'(model_pred(3'd3, 32'd3, 32'd9))) $display("[TB] FAIL next_result: got %h want %h", bus.result, WIDTH'(model_pred(3'd3, 32'd3, 32'd9))); else pass_count++;
    popResult();
  endtask

  // Reset in the middle of a scan discards the compare.
  task automatic test_reset_mid_scan();
    logic [WIDTH-1:0] res;
    logic eq, lt;
    int lat;
    logic seen;
    @(negedge clk);
    bus.a = 32'h12345678;
    bus.b = 32'h12345678;
    bus.cmp_op = 3'd0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_count++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL midrst_out_valid: got %b want 0", bus.out_valid); else pass_count++;
    check_count++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL midrst_in_ready: got %b want 1", bus.in_ready); else pass_count++;
    check_count++; if (bus.result !== '0 || bus.eq_flag !== 1'b0) $display("[TB] FAIL midrst_outputs: got result=%h eq=%b want 0 0", bus.result, bus.eq_flag); else pass_count++;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (NCHUNK + 2) begin
      @(posedge clk);
      #1;
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    check_count++; if (seen !== 1'b0) $display("[TB] FAIL midrst_stale: got out_valid=1 want 0"); else pass_count++;
    applyStimulus(32'd5, 32'd3, 3'd6, lat, res, eq, lt);
    check_count++; if (res !== WIDTH'(1)) $display("[TB] FAIL midrst_gt_result: got %h want 1", res); else pass_count++;
    check_count++; if (lat !== model_latency(32'd5, 32'd3)) $display("[TB] FAIL midrst_gt_latency: got %0d want %0d", lat, model_latency(32'd5, 32'd3)); else pass_count++;
    popResult();
  endtask

  // Random operands biased towards shared leading chunks and sign boundaries.
  task automatic test_random();
    logic [WIDTH-1:0] ra, rb, res;
    logic [2:0] rop;
    logic eq, lt;
    int lat, mode, k;
    for (int n = 0; n < 40; n++) begin
      ra   = $urandom;
      mode = $urandom_range(0, 3);
      case (mode)
        0: rb = $urandom;
        1: rb = ra;
        2: begin
          k  = $urandom_range(0, NCHUNK - 1);
          rb = ra ^ (WIDTH'($urandom_range(1, 255)) << (k * CHUNK));
        end
        default: begin
          ra = ($urandom_range(0, 1) == 1) ? 32'h80000000 : 32'h7FFFFFFF;
          rb = WIDTH'($urandom_range(0, 3)) ^ (($urandom_range(0, 1) == 1) ? 32'h80000000 : 32'h0);
        end
      endcase
      rop = 3'($urandom_range(0, 7));
      applyStimulus(ra, rb, rop, lat, res, eq, lt);
      check_count++; if (lat !== model_latency(ra, rb)) $display("[TB] FAIL rnd%0d_latency: got %0d want %0d", n, lat, model_latency(ra, rb)); else pass_count++;
      check_count++; if (res !== WIDTH'(model_pred(rop, ra, rb))) $display("[TB] FAIL rnd%0d_result: op %0d a %h b %h got %h want %h", n, rop, ra, rb, res, WIDTH'(model_pred(rop, ra, rb))); else pass_count++;
      check_count++; if (eq !== (ra == rb)) $display("[TB] FAIL rnd%0d_eq: got %b want %b", n, eq, ra == rb); else pass_count++;
      check_count++; if (lt !== model_lt(rop, ra, rb)) $display("[TB] FAIL rnd%0d_lt: got %b want %b", n, lt, model_lt(rop, ra, rb)); else pass_count++;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      popResult();
    end
  endtask

  // Test sequence.
  initial begin
    clk = 1'b0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cmp_op    = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_scan();
    test_random();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d so far", pass_count, check_count);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
